alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 154 +++++++++++++++
 tb/tb_alu_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// Each operation is accepted in IDLE, computed in EXEC and held in RESP until taken.
module alu_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_in1,
    input  logic [31:0] req0_in2,
    input  logic [3:0]  req0_ctrl,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_in1,
    input  logic [31:0] req1_in2,
    input  logic [3:0]  req1_ctrl,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_out,
    output logic        rsp0_zero,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_out,
    output logic        rsp1_zero,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_out
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        last_grant_r;
    logic        id_r;
    logic [31:0] in1_r;
    logic [31:0] in2_r;
    logic [3:0]  ctrl_r;
    logic [31:0] result_r;

    logic        grant0_s;
    logic        grant1_s;
    logic        accept_s;
    logic        rsp_done_s;
    logic        exec_s;

    function automatic logic is_zero(input logic [31:0] value);
        return (value == 32'd0);
    endfunction

    // Grant decision: a lone valid wins, a tie goes to whoever was not served last.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if ((state_r == IDLE) && rst_n) begin
            if (req0_valid && req1_valid) begin
                if (last_grant_r) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end else if (req0_valid) begin
                grant0_s = 1'b1;
            end else if (req1_valid) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign accept_s   = grant0_s | grant1_s;
    assign rsp_done_s = (state_r == RESP) && (id_r ? rsp1_ready : rsp0_ready);
    assign exec_s     = (state_r == EXEC);

    // Next-state logic for the IDLE -> EXEC -> RESP cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: state_nxt_s = RESP;
            RESP: begin
                if (rsp_done_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand/ID capture on acceptance and result capture at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
            id_r         <= 1'b0;
            in1_r        <= 32'd0;
            in2_r        <= 32'd0;
            ctrl_r       <= 4'd0;
            result_r     <= 32'd0;
        end else begin
            if (accept_s) begin
                last_grant_r <= grant1_s;
                id_r         <= grant1_s;
                in1_r        <= grant1_s ? req1_in1  : req0_in1;
                in2_r        <= grant1_s ? req1_in2  : req0_in2;
                ctrl_r       <= grant1_s ? req1_ctrl : req0_ctrl;
            end
            if (exec_s) begin
                result_r <= alu_out;
            end
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;

    assign rsp0_valid = (state_r == RESP) && !id_r;
    assign rsp1_valid = (state_r == RESP) && id_r;
    assign rsp0_out   = rsp0_valid ? result_r : 32'd0;
    assign rsp1_out   = rsp1_valid ? result_r : 32'd0;
    assign rsp0_zero  = rsp0_valid && is_zero(result_r);
    assign rsp1_zero  = rsp1_valid && is_zero(result_r);

    // The ALU sees latched operands only while executing, zeros otherwise.
    assign alu_in1  = exec_s ? in1_r  : 32'd0;
    assign alu_in2  = exec_s ? in2_r  : 32'd0;
    assign alu_ctrl = exec_s ? ctrl_r : 4'd0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, hand-written corner sequences,
// then random traffic checked against a transaction-level model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rv;
    logic [1:0]  rr;
    logic [3:0]  rc [2];
    logic [31:0] ra [2];
    logic [31:0] rb [2];

    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero;
    logic [31:0] rsp0_out, rsp1_out;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic [3:0]  alu_ctrl;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (rv[0]),
        .req0_ready (req0_ready),
        .req0_in1   (ra[0]),
        .req0_in2   (rb[0]),
        .req0_ctrl  (rc[0]),
        .req1_valid (rv[1]),
        .req1_ready (req1_ready),
        .req1_in1   (ra[1]),
        .req1_in2   (rb[1]),
        .req1_ctrl  (rc[1]),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rr[0]),
        .rsp0_out   (rsp0_out),
        .rsp0_zero  (rsp0_zero),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rr[1]),
        .rsp1_out   (rsp1_out),
        .rsp1_zero  (rsp1_zero),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_ctrl   (alu_ctrl),
        .alu_out    (alu_out)
    );

    function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return (a < b) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    // Shared ALU environment model.
    always_comb alu_out = alu_fn(alu_ctrl, alu_in1, alu_in2);

    typedef struct {
        logic        id;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        zero;
    } vec_t;

    vec_t vt [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        rv[id] = 1'b1;
        rc[id] = c;
        ra[id] = a;
        rb[id] = b;
    endtask

    task automatic do_reset();
        rv    = 2'b00;
        rr    = 2'b00;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic run_vec(input int k);
        int id;
        id = int'(vt[k].id);
        rv = 2'b00;
        rr = 2'b11;
        set_req(id, vt[k].ctrl, vt[k].a, vt[k].b);
        #1;
        check("accept_ready", id ? req1_ready : req0_ready, 1'b1);
        check("other_ready", id ? req0_ready : req1_ready, 1'b0);
        tick();
        rv[id] = 1'b0;
        #1;
        check("exec_ctrl", alu_ctrl, vt[k].ctrl);
        check("exec_in1", alu_in1, vt[k].a);
        check("exec_in2", alu_in2, vt[k].b);
        check("exec_no_rsp", rsp0_valid | rsp1_valid, 1'b0);
        tick();
        check("resp_valid", id ? rsp1_valid : rsp0_valid, 1'b1);
        check("resp_other", id ? rsp0_valid : rsp1_valid, 1'b0);
        check("resp_out", id ? rsp1_out : rsp0_out, vt[k].exp);
        check("resp_zero", id ? rsp1_zero : rsp0_zero, vt[k].zero);
        check("resp_alu_idle", alu_ctrl, 4'd0);
        tick();
        check("after_resp", rsp0_valid | rsp1_valid, 1'b0);
    endtask

    // Transaction-level reference state for the random phase.
    logic        m_out;
    logic        m_id;
    int          m_age;
    logic        m_last;
    logic [3:0]  m_ctrl;
    logic [31:0] m_a, m_b, m_exp;

    function automatic logic [3:0] rand_ctrl();
        int s;
        s = $urandom_range(0, 6);
        case (s)
            0: return 4'b0000;
            1: return 4'b0001;
            2: return 4'b0010;
            3: return 4'b0110;
            4: return 4'b0111;
            5: return 4'b1100;
            default: return 4'($urandom);
        endcase
    endfunction

    initial begin
        logic e_r0, e_r1, e_v0, e_v1, acc0, acc1, done;
        logic [31:0] x;

        vt[0] = '{1'b0, 4'b0010, 32'd5,          32'd7,          32'd12,         1'b0};
        vt[1] = '{1'b1, 4'b0000, 32'h0000_00FF,  32'h0000_000F,  32'h0000_000F,  1'b0};
        vt[2] = '{1'b0, 4'b0001, 32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  1'b0};
        vt[3] = '{1'b1, 4'b0110, 32'd10,         32'd3,          32'd7,          1'b0};
        vt[4] = '{1'b0, 4'b0111, 32'd3,          32'd4,          32'd1,          1'b0};
        vt[5] = '{1'b1, 4'b0111, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};
        vt[6] = '{1'b0, 4'b1100, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b0};
        vt[7] = '{1'b0, 4'b1111, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1'b1};
        vt[8] = '{1'b1, 4'b0110, 32'd9,          32'd9,          32'd0,          1'b1};

        // Reset state with a request already pending.
        rst_n = 1'b0;
        rr    = 2'b11;
        rv    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            rc[i] = 4'd0;
            ra[i] = 32'd0;
            rb[i] = 32'd0;
        end
        set_req(0, 4'b0010, 32'd5, 32'd7);
        repeat (2) @(posedge clk);
        #1;
        check("rst_req0_ready", req0_ready, 1'b0);
        check("rst_rsp0_valid", rsp0_valid, 1'b0);
        check("rst_rsp0_zero", rsp0_zero, 1'b0);
        check("rst_rsp0_out", rsp0_out, 32'd0);
        check("rst_alu_in1", alu_in1, 32'd0);
        check("rst_alu_ctrl", alu_ctrl, 4'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 9; k++) run_vec(k);

        // Tie from reset: requester 0 first, then requester 1.
        do_reset();
        rr = 2'b11;
        set_req(0, 4'b0110, 32'd9, 32'd9);
        set_req(1, 4'b0001, 32'h0000_00F0, 32'h0000_000F);
        #1;
        check("tie_ready0", req0_ready, 1'b1);
        check("tie_ready1", req1_ready, 1'b0);
        tick();
        rv[0] = 1'b0;
        #1;
        check("tie_exec_ready1", req1_ready, 1'b0);
        tick();
        check("tie_rsp0_valid", rsp0_valid, 1'b1);
        check("tie_rsp0_out", rsp0_out, 32'd0);
        check("tie_rsp0_zero", rsp0_zero, 1'b1);
        check("tie_resp_ready1", req1_ready, 1'b0);
        tick();
        check("tie_idle_ready1", req1_ready, 1'b1);
        tick();
        rv[1] = 1'b0;
        #1;
        tick();
        check("tie_rsp1_valid", rsp1_valid, 1'b1);
        check("tie_rsp1_out", rsp1_out, 32'h0000_00FF);
        check("tie_rsp1_zero", rsp1_zero, 1'b0);
        tick();

        // Continuous contention alternates grants; 3 cycles per op.
        set_req(0, 4'b0010, 32'd1, 32'd2);
        set_req(1, 4'b0000, 32'd6, 32'd3);
        #1;
        for (int k = 0; k < 6; k++) begin
            check("rr_grant", {req1_ready, req0_ready}, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            tick();
            check("rr_rsp_valid", {rsp1_valid, rsp0_valid}, (k % 2 == 0) ? 2'b01 : 2'b10);
            check("rr_rsp_out", (k % 2 == 0) ? rsp0_out : rsp1_out, (k % 2 == 0) ? 32'd3 : 32'd2);
            tick();
        end
        rv = 2'b00;

        // Back-pressure on requester 1 while requester 0 waits.
        rr = 2'b01;
        set_req(1, 4'b0111, 32'd3, 32'd4);
        #1;
        check("bp_ready1", req1_ready, 1'b1);
        tick();
        rv = 2'b00;
        set_req(0, 4'b0010, 32'd1, 32'd1);
        #1;
        check("bp_exec_ready0", req0_ready, 1'b0);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp1_valid", rsp1_valid, 1'b1);
            check("bp_rsp1_out", rsp1_out, 32'd1);
            check("bp_rsp1_zero", rsp1_zero, 1'b0);
            check("bp_ready0", req0_ready, 1'b0);
            check("bp_rsp0_valid", rsp0_valid, 1'b0);
            tick();
        end
        rr[1] = 1'b1;
        #1;
        check("bp_done_ready0", req0_ready, 1'b0);
        tick();
        check("bp_idle_ready0", req0_ready, 1'b1);
        check("bp_idle_rsp1", rsp1_valid, 1'b0);
        tick();
        rv = 2'b00;
        #1;
        tick();
        check("bp_rsp0_out", rsp0_out, 32'd2);
        tick();

        // Reset during EXEC discards the operation.
        rr = 2'b11;
        set_req(0, 4'b0000, 32'h0000_00FF, 32'h0000_000F);
        #1;
        check("rx_ready0", req0_ready, 1'b1);
        tick();
        rv = 2'b00;
        #1;
        check("rx_exec_in1", alu_in1, 32'h0000_00FF);
        rst_n = 1'b0;
        #1;
        check("rx_alu_in1", alu_in1, 32'd0);
        check("rx_alu_in2", alu_in2, 32'd0);
        check("rx_rsp0_valid", rsp0_valid, 1'b0);
        check("rx_ready0_low", req0_ready, 1'b0);
        tick();
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rx_no_rsp0", rsp0_valid, 1'b0);
            tick();
        end
        set_req(0, 4'b0010, 32'd1, 32'd1);
        set_req(1, 4'b0010, 32'd2, 32'd2);
        #1;
        check("rx_tie_ready0", req0_ready, 1'b1);
        check("rx_tie_ready1", req1_ready, 1'b0);

        // Random traffic against the transaction-level model.
        do_reset();
        m_out  = 1'b0;
        m_id   = 1'b0;
        m_age  = 0;
        m_last = 1'b1;
        m_ctrl = 4'd0;
        m_a    = 32'd0;
        m_b    = 32'd0;
        m_exp  = 32'd0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            e_r0 = !m_out && rv[0] && (!rv[1] || m_last);
            e_r1 = !m_out && rv[1] && (!rv[0] || !m_last);
            e_v0 = m_out && (m_age >= 1) && !m_id;
            e_v1 = m_out && (m_age >= 1) && m_id;
            check("rnd_ready0", req0_ready, e_r0);
            check("rnd_ready1", req1_ready, e_r1);
            check("rnd_rsp0_valid", rsp0_valid, e_v0);
            check("rnd_rsp1_valid", rsp1_valid, e_v1);
            if (e_v0) check("rnd_rsp0_out", rsp0_out, m_exp);
            if (e_v0) check("rnd_rsp0_zero", rsp0_zero, m_exp == 32'd0);
            if (e_v1) check("rnd_rsp1_out", rsp1_out, m_exp);
            if (e_v1) check("rnd_rsp1_zero", rsp1_zero, m_exp == 32'd0);
            check("rnd_alu_ctrl", alu_ctrl, (m_out && m_age == 0) ? m_ctrl : 4'd0);
            check("rnd_alu_in1", alu_in1, (m_out && m_age == 0) ? m_a : 32'd0);
            check("rnd_alu_in2", alu_in2, (m_out && m_age == 0) ? m_b : 32'd0);
            acc0 = e_r0;
            acc1 = e_r1;
            done = (e_v0 && rr[0]) || (e_v1 && rr[1]);
            tick();
            if (done) begin
                m_out = 1'b0;
            end else if (m_out) begin
                m_age++;
            end
            if (acc0 || acc1) begin
                m_out  = 1'b1;
                m_age  = 0;
                m_id   = acc1;
                m_last = acc1;
                m_ctrl = acc1 ? rc[1] : rc[0];
                m_a    = acc1 ? ra[1] : ra[0];
                m_b    = acc1 ? rb[1] : rb[0];
                m_exp  = alu_fn(m_ctrl, m_a, m_b);
                rv[acc1] = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                if (!rv[i]) begin
                    if ($urandom_range(0, 1) == 0) begin
                        x = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
                        set_req(i, rand_ctrl(), x,
                                ($urandom_range(0, 3) == 0) ? x : (($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : $urandom));
                    end
                end else if ($urandom_range(0, 9) == 0) begin
                    rv[i] = 1'b0;
                end
            end
            rr = 2'($urandom_range(0, 3));
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
